// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, FSM states, default widths.
package exec_pkg;

  localparam int unsigned N_DEFAULT  = 64;
  localparam int unsigned CW_DEFAULT = 4;

  // AluControl encodings
  localparam logic [3:0] ALU_AND    = 4'b0000;
  localparam logic [3:0] ALU_OR     = 4'b0001;
  localparam logic [3:0] ALU_ADD    = 4'b0010;
  localparam logic [3:0] ALU_SUB    = 4'b0110;
  localparam logic [3:0] ALU_PASS_B = 4'b0111;

  // Multiplier sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } exec_state_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU; unknown opcodes produce zero.
module alu
  import exec_pkg::*;
#(
  parameter int unsigned N  = N_DEFAULT,
  parameter int unsigned CW = CW_DEFAULT
) (
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  logic [CW-1:0] alu_control,
  output logic [N-1:0]  result_c
);

  // Opcode decode
  always_comb begin
    result_c = '0;
    case (alu_control)
      CW'(ALU_AND):    result_c = a & b;
      CW'(ALU_OR):     result_c = a | b;
      CW'(ALU_ADD):    result_c = a + b;
      CW'(ALU_SUB):    result_c = a - b;
      CW'(ALU_PASS_B): result_c = b;
      default:         result_c = '0;
    endcase
  end

endmodule

// File: rtl/execute_pipe.sv
// Execute stage: single-cycle ALU path plus optional iterative shift-add multiplier.
// Build option: define EXECUTE_MUL_EN to include the multiplier FSM and datapath;
// without it MulOp is ignored and every operation goes through the ALU.
module execute_pipe
  import exec_pkg::*;
#(
  parameter int unsigned N  = N_DEFAULT,
  parameter int unsigned CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          AluSrc,
  input  logic [CW-1:0] AluControl,
  input  logic          MulOp,
  input  logic [N-1:0]  PC_E,
  input  logic [N-1:0]  signImm_E,
  input  logic [N-1:0]  readData1_E,
  input  logic [N-1:0]  readData2_E,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  PCBranch_M,
  output logic [N-1:0]  aluResult_M,
  output logic [N-1:0]  writeData_M,
  output logic          zero_M
);

  logic [N-1:0] op_b;
  logic [N-1:0] alu_res;
  logic [N-1:0] pc_branch;
  logic         out_free;
  logic         in_xfer;

  logic         load;
  logic [N-1:0] load_pcb;
  logic [N-1:0] load_alu;
  logic [N-1:0] load_wd;

  assign op_b      = AluSrc ? signImm_E : readData2_E;
  assign pc_branch = PC_E + (signImm_E << 2);
  assign out_free  = !out_valid || out_ready;
  assign in_xfer   = in_valid && in_ready;

  alu #(
    .N  (N),
    .CW (CW)
  ) u_alu (
    .a           (readData1_E),
    .b           (op_b),
    .alu_control (AluControl),
    .result_c    (alu_res)
  );

`ifdef EXECUTE_MUL_EN
  localparam int unsigned CNT_W = $clog2(N);

  exec_state_e      state;
  exec_state_e      state_next;
  logic [CNT_W-1:0] mul_cnt;
  logic [N-1:0]     mul_a;
  logic [N-1:0]     mul_b;
  logic [N-1:0]     mul_acc;
  logic [N-1:0]     mul_pcb;
  logic [N-1:0]     mul_wd;
  logic             mul_start;
  logic             mul_done;

  assign in_ready  = (state == IDLE) && !flush && out_free;
  assign mul_start = in_xfer && MulOp;
  assign mul_done  = (state == HOLD) && out_free && !flush;

  // Next-state: flush always returns to IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mul_start) state_next = MUL;
      MUL:     if (mul_cnt == CNT_W'(N - 1)) state_next = HOLD;
      HOLD:    if (out_free) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Shift-add multiplier: one multiplier bit consumed per MUL cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_cnt <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      mul_acc <= '0;
      mul_pcb <= '0;
      mul_wd  <= '0;
    end else if (mul_start) begin
      mul_cnt <= '0;
      mul_a   <= readData1_E;
      mul_b   <= op_b;
      mul_acc <= '0;
      mul_pcb <= pc_branch;
      mul_wd  <= readData2_E;
    end else if ((state == MUL) && !flush) begin
      if (mul_b[0]) mul_acc <= mul_acc + mul_a;
      mul_a   <= mul_a << 1;
      mul_b   <= mul_b >> 1;
      mul_cnt <= mul_cnt + CNT_W'(1);
    end
  end

  // Output load source: ALU result on transfer, product when HOLD drains
  always_comb begin
    load     = 1'b0;
    load_pcb = pc_branch;
    load_alu = alu_res;
    load_wd  = readData2_E;
    if (in_xfer && !MulOp) begin
      load = 1'b1;
    end else if (mul_done) begin
      load     = 1'b1;
      load_pcb = mul_pcb;
      load_alu = mul_acc;
      load_wd  = mul_wd;
    end
  end
`else
  logic unused_mul_op;

  assign unused_mul_op = MulOp;
  assign in_ready      = !flush && out_free;

  // Output load source: every transfer is an ALU op
  always_comb begin
    load     = in_xfer;
    load_pcb = pc_branch;
    load_alu = alu_res;
    load_wd  = readData2_E;
  end
`endif

  // Memory-stage output register; holds while stalled, flush drops it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid   <= 1'b0;
      PCBranch_M  <= '0;
      aluResult_M <= '0;
      writeData_M <= '0;
      zero_M      <= 1'b1;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid   <= 1'b1;
      PCBranch_M  <= load_pcb;
      aluResult_M <= load_alu;
      writeData_M <= load_wd;
      zero_M      <= (load_alu == '0);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/execute_pipe.md
EXECUTE_PIPE -- requirements
Module: execute_pipe

Interface
REQ-001 SHALL have parameter N, default 64: datapath width in bits (N >= 8, power of 2).
REQ-002 SHALL have parameter CW, default 4: AluControl width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  decode stage presents an operation.
REQ-006 SHALL have port in_ready  output  1  block accepts an operation this cycle.
REQ-007 SHALL have ports AluSrc  input  1 and AluControl  input  CW: operand-B select and ALU operation.
REQ-008 SHALL have port MulOp  input  1  operation is an unsigned multiply (low N bits of a*b).
REQ-009 SHALL have ports PC_E, signImm_E, readData1_E, readData2_E  input  N each: decode-stage operands.
REQ-010 SHALL have port flush  input  1  discards the in-flight and registered operation.
REQ-011 SHALL have ports out_valid  output  1 and out_ready  input  1: memory-stage handshake.
REQ-012 SHALL have ports PCBranch_M, aluResult_M, writeData_M  output  N and zero_M  output  1: registered results.

Function
REQ-013 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-014 in_ready SHALL equal (state==IDLE) && !flush && (!out_valid || out_ready).
REQ-015 Operand B SHALL be signImm_E when AluSrc=1, else readData2_E; operand A is readData1_E.
REQ-016 PCBranch SHALL be PC_E + (signImm_E << 2), truncated to N bits; writeData SHALL be readData2_E.
REQ-017 Non-multiply op: results SHALL appear on outputs with out_valid=1 the cycle after transfer (latency 1); back-to-back transfers sustain 1 op/cycle.
REQ-018 zero_M SHALL be 1 iff aluResult_M == 0.
REQ-019 Multiply op SHALL enter FSM state MUL: captures A, B, PCBranch, writeData; iterative shift-add, one multiplier bit per cycle, counter width $clog2(N).
REQ-020 FSM states SHALL be IDLE, MUL, HOLD: IDLE->MUL on multiply transfer; MUL->HOLD after N iterations; HOLD->IDLE when output register free (!out_valid || out_ready), loading result with out_valid=1.
REQ-021 Multiply result SHALL be valid on outputs no earlier than N+1 cycles after transfer; in_ready SHALL be 0 throughout MUL and HOLD.
REQ-022 Registered outputs SHALL hold stable while out_valid && !out_ready.
REQ-023 flush SHALL clear out_valid, abort MUL/HOLD to IDLE next edge, and drop any concurrent input (flush wins over transfer).
REQ-024 Output transfer and new input transfer in the same cycle SHALL both occur; new result replaces old.
REQ-025 Unknown AluControl encodings SHALL yield aluResult 0.

Reset
REQ-026 On reset low: state=IDLE, out_valid=0, PCBranch_M=aluResult_M=writeData_M=0, zero_M=1, multiply counter=0, regardless of clock.
REQ-027 Reset asserted mid-multiply SHALL abandon the operation with no output produced after release.

Configuration
REQ-028 Macro EXECUTE_MUL_EN SHALL compile in the multiplier FSM and datapath.
REQ-029 Without EXECUTE_MUL_EN: MulOp SHALL be ignored (op executes as ALU op per AluControl), FSM absent, in_ready = !flush && (!out_valid || out_ready).

Structure
REQ-030 Package exec_pkg SHALL hold AluControl encodings (AND, OR, ADD, SUB, PASS_B), the FSM state enum, and default N.
REQ-031 The existing alu module SHALL be instantiated as the single sub-module; multiplier stays inline.

Verification
REQ-032 ADD, A=5, B=readData2=7, AluSrc=0 -> next cycle aluResult_M=12, zero_M=0, out_valid=1.
REQ-033 SUB, A=9, signImm=9, AluSrc=1, PC_E=0x100 -> aluResult_M=0, zero_M=1, PCBranch_M=0x124.
REQ-034 MulOp, A=0xFFFF_FFFF_FFFF_FFFF, B=3 (N=64) -> in_ready low N+1 cycles, then aluResult_M=0xFFFF_FFFF_FFFF_FFFD.
REQ-035 out_ready=0 with out_valid=1, new in_valid -> in_ready=0, outputs unchanged until out_ready=1.
REQ-036 flush at cycle 10 of a multiply, with in_valid=1 -> out_valid=0 next cycle, state IDLE, input dropped, no late result.
REQ-037 reset low mid-multiply, then released -> all outputs at reset values, in_ready=1 next cycle.
